debounce_onepulse: RTL and testbench

//  Converts a raw, asynchronous, possibly bouncing level (push button / external strobe) into clean

---
 rtl/debounce_onepulse.sv | 181 ++++++++++++++++++
 tb/tb_debounce_onepulse.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_onepulse.sv
// -----------------------------------------------------------------------------
// debounce_onepulse
//
// Turns a raw, asynchronous, possibly bouncing active-high level (push button,
// external strobe) into clean events for the control FSMs:
//   * pulse      - one cycle per accepted press
//   * long_pulse - one cycle per press held for LONG_LEN cycles in HELD
//   * held       - debounced level (high in HELD and RELEASE_DB)
//
// The input goes through a two-flop synchroniser. The FSM only ever looks at the
// synchronised copy s. Both press and release must stay stable for DB_LEN
// consecutive samples before they are accepted.
//
// Parameters
//   DB_LEN    cycles s must be stable before a press/release is accepted (>= 2)
//   DB_W      width of db_cnt; must hold DB_LEN-1
//   LONG_LEN  cycles spent in HELD before long_pulse fires (>= 2)
//   LONG_W    width of hold_cnt; must hold LONG_LEN
//
// Ports
//   clk         in   clock, all logic on posedge
//   reset       in   asynchronous, active-high; clears all state
//   level_in    in   raw asynchronous level, active-high
//   pulse       out  registered, 1 cycle per accepted press
//   long_pulse  out  registered, 1 cycle per press held >= LONG_LEN cycles
//   held        out  registered debounced level
// -----------------------------------------------------------------------------
module debounce_onepulse #(
   parameter int DB_LEN   = 65536,
   parameter int DB_W     = 17,
   parameter int LONG_LEN = 8388608,
   parameter int LONG_W   = 24
) (
   input  logic clk,
   input  logic reset,
   input  logic level_in,
   output logic pulse,
   output logic long_pulse,
   output logic held
);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_PRESS_DB   = 2'd1,
      S_HELD       = 2'd2,
      S_RELEASE_DB = 2'd3
   } state_t;

   // Width-exact compare constants so the counters never compare against a
   // wider integer expression.
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_LEN - 1);
   localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
   localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_LEN);
   localparam logic [LONG_W-1:0] LONG_PRE  = LONG_W'(LONG_LEN - 1);
   localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);

   logic              sync1_reg;
   logic              sync2_reg;
   logic              s;

   state_t            state_reg,      state_next;
   logic [DB_W-1:0]   db_cnt_reg,     db_cnt_next;
   logic [LONG_W-1:0] hold_cnt_reg,   hold_cnt_next;
   logic              pulse_reg,      pulse_next;
   logic              long_pulse_reg, long_pulse_next;
   logic              held_reg,       held_next;

   // ---------------------------------------------------------------------------
   // Two-flop synchroniser for the asynchronous input
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
      end else begin
         sync1_reg <= level_in;
         sync2_reg <= sync1_reg;
      end
   end

   assign s = sync2_reg;

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= S_IDLE;
         db_cnt_reg     <= '0;
         hold_cnt_reg   <= '0;
         pulse_reg      <= 1'b0;
         long_pulse_reg <= 1'b0;
         held_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         db_cnt_reg     <= db_cnt_next;
         hold_cnt_reg   <= hold_cnt_next;
         pulse_reg      <= pulse_next;
         long_pulse_reg <= long_pulse_next;
         held_reg       <= held_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      db_cnt_next     = db_cnt_reg;
      hold_cnt_next   = hold_cnt_reg;
      pulse_next      = 1'b0;
      long_pulse_next = 1'b0;

      case (state_reg)
         S_IDLE: begin
            db_cnt_next = '0;
            if (s) begin
               state_next  = S_PRESS_DB;
               db_cnt_next = DB_ONE;
            end
         end

         S_PRESS_DB: begin
            if (!s) begin
               // Glitch shorter than the debounce window: drop it silently.
               state_next  = S_IDLE;
               db_cnt_next = '0;
            end else if (db_cnt_reg == DB_LAST) begin
               state_next    = S_HELD;
               pulse_next    = 1'b1;
               hold_cnt_next = '0;
               db_cnt_next   = '0;
            end else begin
               db_cnt_next = db_cnt_reg + DB_ONE;
            end
         end

         S_HELD: begin
            // Saturating at LONG_LEN is what limits long_pulse to one per press.
            if (hold_cnt_reg != LONG_MAX) begin
               hold_cnt_next = hold_cnt_reg + LONG_ONE;
            end
            if (hold_cnt_reg == LONG_PRE) begin
               long_pulse_next = 1'b1;
            end
            if (!s) begin
               state_next  = S_RELEASE_DB;
               db_cnt_next = DB_ONE;
            end
         end

         S_RELEASE_DB: begin
            // hold_cnt is frozen here; a release bounce resumes it in HELD.
            if (s) begin
               state_next  = S_HELD;
               db_cnt_next = '0;
            end else if (db_cnt_reg == DB_LAST) begin
               state_next    = S_IDLE;
               db_cnt_next   = '0;
               hold_cnt_next = '0;
            end else begin
               db_cnt_next = db_cnt_reg + DB_ONE;
            end
         end

         default: begin
            state_next    = S_IDLE;
            db_cnt_next   = '0;
            hold_cnt_next = '0;
         end
      endcase

      // held is registered from the next state so it lines up with the state.
      held_next = (state_next == S_HELD) || (state_next == S_RELEASE_DB);
   end

   assign pulse      = pulse_reg;
   assign long_pulse = long_pulse_reg;
   assign held       = held_reg;

endmodule

// File: tb/tb_debounce_onepulse.sv
// -----------------------------------------------------------------------------
// tb_debounce_onepulse
//
// Directed bench for debounce_onepulse with DB_LEN=4, LONG_LEN=10. Each driven
// input cycle runs a run-length reference (consecutive samples that disagree
// with the accepted level, plus a count of cycles spent held) and pushes the
// expected outputs onto a queue; the entry is popped and compared one clock
// later. Scenario-level checks compare event timing against the latencies the
// block is meant to have.
// -----------------------------------------------------------------------------
module tb_debounce_onepulse;

   localparam int DB_LEN   = 4;
   localparam int DB_W     = 3;
   localparam int LONG_LEN = 10;
   localparam int LONG_W   = 4;

   logic clk      = 1'b0;
   logic reset    = 1'b1;
   logic level_in = 1'b0;
   logic pulse;
   logic long_pulse;
   logic held;

   debounce_onepulse #(
      .DB_LEN  (DB_LEN),
      .DB_W    (DB_W),
      .LONG_LEN(LONG_LEN),
      .LONG_W  (LONG_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .level_in  (level_in),
      .pulse     (pulse),
      .long_pulse(long_pulse),
      .held      (held)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic p;
      logic lp;
      logic h;
   } exp_t;

   exp_t exp_q[$];

   // reference state
   bit m_sync1;
   bit m_sync2;
   bit m_held;
   int m_run;
   int m_hold;

   int n_checks = 0;
   int n_errors = 0;

   // per-scenario bookkeeping
   int   step_idx;
   int   pulse_cnt;
   int   long_cnt;
   int   pulse_at;
   int   long_at;
   int   held_fall_at;
   int   held_rise_cnt;
   logic prev_held;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_sync1 = 1'b0;
      m_sync2 = 1'b0;
      m_held  = 1'b0;
      m_run   = 0;
      m_hold  = 0;
      exp_q.delete();
   endtask

   // Expected outputs after the coming clock edge, given the input driven now.
   task automatic model_edge(input bit v, output exp_t e);
      bit s;
      bit in_held_state;
      s  = m_sync2;
      e  = '0;
      in_held_state = m_held && (m_run == 0);
      if (in_held_state && (m_hold < LONG_LEN)) begin
         m_hold++;
         if (m_hold == LONG_LEN) e.lp = 1'b1;
      end
      if (s != m_held) m_run++;
      else             m_run = 0;
      if (m_run == DB_LEN) begin
         m_held = ~m_held;
         m_run  = 0;
         m_hold = 0;
         if (m_held) e.p = 1'b1;
      end
      e.h     = m_held;
      m_sync2 = m_sync1;
      m_sync1 = v;
   endtask

   task automatic scn_start();
      step_idx      = 0;
      pulse_cnt     = 0;
      long_cnt      = 0;
      pulse_at      = -1;
      long_at       = -1;
      held_fall_at  = -1;
      held_rise_cnt = 0;
      prev_held     = held;
   endtask

   task automatic step(input bit v);
      exp_t e;
      exp_t got;
      level_in = v;
      model_edge(v, e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("queue_empty", 32'd0, 32'd1);
      end else begin
         got = exp_q.pop_front();
         check($sformatf("pulse@%0d", step_idx),      pulse,      got.p);
         check($sformatf("long_pulse@%0d", step_idx), long_pulse, got.lp);
         check($sformatf("held@%0d", step_idx),       held,       got.h);
      end
      if (pulse === 1'b1) begin
         pulse_cnt++;
         pulse_at = step_idx;
      end
      if (long_pulse === 1'b1) begin
         long_cnt++;
         long_at = step_idx;
      end
      if (prev_held === 1'b1 && held === 1'b0) held_fall_at = step_idx;
      if (prev_held === 1'b0 && held === 1'b1) held_rise_cnt++;
      prev_held = held;
      step_idx++;
   endtask

   task automatic run(input bit v, input int n);
      for (int i = 0; i < n; i++) step(v);
   endtask

   task automatic hold_reset(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check({tag, "_pulse"}, pulse,      1'b0);
         check({tag, "_long"},  long_pulse, 1'b0);
         check({tag, "_held"},  held,       1'b0);
      end
      reset = 1'b0;
   endtask

   initial begin
      // Power-on reset
      reset    = 1'b1;
      level_in = 1'b0;
      model_reset();
      hold_reset(2, "por");
      run(1'b0, 4);

      // Steady press of 12 cycles: pulse and held after E0+5, long not reached
      scn_start();
      run(1'b1, 12);
      run(1'b0, 8);
      check("t2_pulse_cnt", pulse_cnt, 1);
      check("t2_pulse_at",  pulse_at,  5);
      check("t2_long_cnt",  long_cnt,  0);
      check("t2_held_fall", held_fall_at, 17);

      // Press one sample shorter than the debounce window: rejected
      scn_start();
      run(1'b1, 3);
      run(1'b0, 8);
      check("t3_pulse_cnt", pulse_cnt, 0);
      check("t3_held_rise", held_rise_cnt, 0);

      // Press then release bounce 0-1-0: one pulse, held falls 5 after last 1->0
      scn_start();
      run(1'b1, 8);
      step(1'b0);
      step(1'b1);
      run(1'b0, 10);
      check("t4_pulse_cnt", pulse_cnt, 1);
      check("t4_held_rise", held_rise_cnt, 1);
      check("t4_held_fall", held_fall_at, 15);

      // Long press of 30 cycles: pulse at 5, one long_pulse at 15
      scn_start();
      run(1'b1, 30);
      check("t5_pulse_at", pulse_at, 5);
      check("t5_long_at",  long_at,  15);
      check("t5_long_cnt", long_cnt, 1);
      check("t5_held",     held,     1'b1);
      run(1'b0, 8);
      check("t5_held_fall", held_fall_at, 35);
      check("t5_long_total", long_cnt, 1);

      // Asynchronous reset while pulse and held are high
      scn_start();
      run(1'b1, 6);
      check("t1_pre_pulse", pulse, 1'b1);
      check("t1_pre_held",  held,  1'b1);
      #3;
      reset    = 1'b1;
      level_in = 1'b0;
      #1;
      check("t1_async_pulse", pulse,      1'b0);
      check("t1_async_long",  long_pulse, 1'b0);
      check("t1_async_held",  held,       1'b0);
      model_reset();
      hold_reset(1, "t1_rst");
      run(1'b0, 6);

      // Reset while in PRESS_DB with level still high: fresh debounce afterwards
      scn_start();
      run(1'b1, 4);
      #3;
      reset = 1'b1;
      model_reset();
      hold_reset(2, "t6_rst");
      scn_start();
      run(1'b1, 10);
      check("t6_pulse_cnt", pulse_cnt, 1);
      check("t6_pulse_at",  pulse_at,  5);
      run(1'b0, 8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
